fpmul_arbiter: RTL and testbench

//  Shares one single-precision floating-point multiplier (operands A/B, 32-bit result, 2-bit especial flag)

---
 rtl/fpmul_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fpmul_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: shares one single-precision multiplier between two requesters.
// Round-robin grant, operands captured at grant and held on the multiplier,
// product returned to the granted port as a one-cycle response pulse.
module fpmul_arbiter #(
  parameter int MUL_LAT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [31:0]      a0,
  input  logic [31:0]      b0,
  input  logic [31:0]      a1,
  input  logic [31:0]      b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  output logic [31:0]      rsp_result,
  output logic [1:0]       rsp_especial,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_start,
  input  logic [31:0]      mul_result,
  input  logic [1:0]       mul_especial,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  // Latency counter only needs to hold MUL_LAT; keep at least one bit.
  localparam int CW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MUL_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              last_r, last_s;
  logic              owner_r, owner_s;
  logic              win_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic              gnt0_r, gnt0_s, gnt1_r, gnt1_s;
  logic              rsp_valid0_r, rsp_valid0_s, rsp_valid1_r, rsp_valid1_s;
  logic [31:0]       rsp_result_r, rsp_result_s;
  logic [1:0]        rsp_especial_r, rsp_especial_s;
  logic [31:0]       mul_a_r, mul_a_s, mul_b_r, mul_b_s;
  logic              mul_start_r, mul_start_s;
  logic              busy_r, busy_s;
  logic [CNT_W-1:0]  ops_done_r, ops_done_s;

  // Next-state, arbitration and next output values; every output is registered below.
  always_comb begin
    state_s        = state_r;
    last_s         = last_r;
    owner_s        = owner_r;
    win_s          = 1'b0;
    cnt_s          = cnt_r;
    gnt0_s         = 1'b0;
    gnt1_s         = 1'b0;
    rsp_valid0_s   = 1'b0;
    rsp_valid1_s   = 1'b0;
    rsp_result_s   = rsp_result_r;
    rsp_especial_s = rsp_especial_r;
    mul_a_s        = mul_a_r;
    mul_b_s        = mul_b_r;
    mul_start_s    = 1'b0;
    ops_done_s     = ops_done_r;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time goes first.
          if (req0 && req1) begin
            win_s = ~last_r;
          end else begin
            win_s = req1;
          end
          last_s      = win_s;
          owner_s     = win_s;
          mul_a_s     = win_s ? a1 : a0;
          mul_b_s     = win_s ? b1 : b0;
          cnt_s       = LAT_LOAD;
          gnt0_s      = ~win_s;
          gnt1_s      = win_s;
          mul_start_s = 1'b1;
          state_s     = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r != {CW{1'b0}}) begin
          cnt_s = cnt_r - CW'(1);
        end else begin
          rsp_result_s   = mul_result;
          rsp_especial_s = mul_especial;
          rsp_valid0_s   = ~owner_r;
          rsp_valid1_s   = owner_r;
          ops_done_s     = ops_done_r + CNT_W'(1);
          state_s        = RESP;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; last starts at 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      last_r         <= 1'b1;
      owner_r        <= 1'b0;
      cnt_r          <= {CW{1'b0}};
      gnt0_r         <= 1'b0;
      gnt1_r         <= 1'b0;
      rsp_valid0_r   <= 1'b0;
      rsp_valid1_r   <= 1'b0;
      rsp_result_r   <= 32'h0000_0000;
      rsp_especial_r <= 2'b00;
      mul_a_r        <= 32'h0000_0000;
      mul_b_r        <= 32'h0000_0000;
      mul_start_r    <= 1'b0;
      busy_r         <= 1'b0;
      ops_done_r     <= {CNT_W{1'b0}};
    end else begin
      state_r        <= state_s;
      last_r         <= last_s;
      owner_r        <= owner_s;
      cnt_r          <= cnt_s;
      gnt0_r         <= gnt0_s;
      gnt1_r         <= gnt1_s;
      rsp_valid0_r   <= rsp_valid0_s;
      rsp_valid1_r   <= rsp_valid1_s;
      rsp_result_r   <= rsp_result_s;
      rsp_especial_r <= rsp_especial_s;
      mul_a_r        <= mul_a_s;
      mul_b_r        <= mul_b_s;
      mul_start_r    <= mul_start_s;
      busy_r         <= busy_s;
      ops_done_r     <= ops_done_s;
    end
  end

  assign gnt0         = gnt0_r;
  assign gnt1         = gnt1_r;
  assign rsp_valid0   = rsp_valid0_r;
  assign rsp_valid1   = rsp_valid1_r;
  assign rsp_result   = rsp_result_r;
  assign rsp_especial = rsp_especial_r;
  assign mul_a        = mul_a_r;
  assign mul_b        = mul_b_r;
  assign mul_start    = mul_start_r;
  assign busy         = busy_r;
  assign ops_done     = ops_done_r;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter: instance p (MUL_LAT=0, CNT_W=16) and
// instance q (MUL_LAT=3, CNT_W=2) driven by a lookup-table multiplier model.
module tb_fpmul_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // ---------------- instance p ----------------
  logic        p_reset, p_req0, p_req1;
  logic [31:0] p_a0, p_b0, p_a1, p_b1;
  logic        p_gnt0, p_gnt1, p_v0, p_v1, p_start, p_busy;
  logic [31:0] p_res, p_mul_a, p_mul_b, p_mul_result;
  logic [1:0]  p_esp, p_mul_especial;
  logic [15:0] p_ops;

  // ---------------- instance q ----------------
  logic        q_reset, q_req0, q_req1;
  logic [31:0] q_a0, q_b0, q_a1, q_b1;
  logic        q_gnt0, q_gnt1, q_v0, q_v1, q_start, q_busy;
  logic [31:0] q_res, q_mul_a, q_mul_b, q_mul_result;
  logic [1:0]  q_esp, q_mul_especial;
  logic [1:0]  q_ops;
  logic [33:0] q_m;
  int          q_age = 0;

  fpmul_arbiter #(.MUL_LAT(0), .CNT_W(16)) u_p (
    .clk(clk), .reset(p_reset), .req0(p_req0), .req1(p_req1),
    .a0(p_a0), .b0(p_b0), .a1(p_a1), .b1(p_b1),
    .gnt0(p_gnt0), .gnt1(p_gnt1), .rsp_valid0(p_v0), .rsp_valid1(p_v1),
    .rsp_result(p_res), .rsp_especial(p_esp),
    .mul_a(p_mul_a), .mul_b(p_mul_b), .mul_start(p_start),
    .mul_result(p_mul_result), .mul_especial(p_mul_especial),
    .busy(p_busy), .ops_done(p_ops));

  fpmul_arbiter #(.MUL_LAT(3), .CNT_W(2)) u_q (
    .clk(clk), .reset(q_reset), .req0(q_req0), .req1(q_req1),
    .a0(q_a0), .b0(q_b0), .a1(q_a1), .b1(q_b1),
    .gnt0(q_gnt0), .gnt1(q_gnt1), .rsp_valid0(q_v0), .rsp_valid1(q_v1),
    .rsp_result(q_res), .rsp_especial(q_esp),
    .mul_a(q_mul_a), .mul_b(q_mul_b), .mul_start(q_start),
    .mul_result(q_mul_result), .mul_especial(q_mul_especial),
    .busy(q_busy), .ops_done(q_ops));

  // Multiplier model: table of hand-computed products; zero operand flags especial=01.
  function automatic logic [33:0] fmodel(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] key;
    key = {a, b};
    if (a == 32'h0000_0000 || b == 32'h0000_0000) return {2'b01, 32'h0000_0000};
    case (key)
      {32'h4000_0000, 32'h4040_0000}: return {2'b00, 32'h40C0_0000}; // 2*3=6
      {32'h3FC0_0000, 32'h4000_0000}: return {2'b00, 32'h4040_0000}; // 1.5*2=3
      {32'h4080_0000, 32'h3F00_0000}: return {2'b00, 32'h4000_0000}; // 4*0.5=2
      default:                        return {2'b11, 32'h7FC0_0000};
    endcase
  endfunction

  assign {p_mul_especial, p_mul_result} = fmodel(p_mul_a, p_mul_b);

  // q multiplier drives X until three edges after it saw mul_start.
  always @(posedge clk) begin
    if (q_start) q_age <= 1;
    else if (q_age < 7) q_age <= q_age + 1;
  end
  assign q_m            = fmodel(q_mul_a, q_mul_b);
  assign q_mul_result   = (q_age >= 3) ? q_m[31:0]  : 32'hxxxx_xxxx;
  assign q_mul_especial = (q_age >= 3) ? q_m[33:32] : 2'bxx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic p_outs(input string tag, input logic g0, input logic g1,
                        input logic v0, input logic v1, input logic b);
    chk({tag, ".gnt0"}, 32'(p_gnt0), 32'(g0));
    chk({tag, ".gnt1"}, 32'(p_gnt1), 32'(g1));
    chk({tag, ".rsp_valid0"}, 32'(p_v0), 32'(v0));
    chk({tag, ".rsp_valid1"}, 32'(p_v1), 32'(v1));
    chk({tag, ".busy"}, 32'(p_busy), 32'(b));
  endtask

  task automatic q_outs(input string tag, input logic g0, input logic g1,
                        input logic v0, input logic v1, input logic b);
    chk({tag, ".gnt0"}, 32'(q_gnt0), 32'(g0));
    chk({tag, ".gnt1"}, 32'(q_gnt1), 32'(g1));
    chk({tag, ".rsp_valid0"}, 32'(q_v0), 32'(v0));
    chk({tag, ".rsp_valid1"}, 32'(q_v1), 32'(v1));
    chk({tag, ".busy"}, 32'(q_busy), 32'(b));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Overall time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_res;

  initial begin
    p_reset = 1'b1; p_req0 = 1'b0; p_req1 = 1'b0;
    p_a0 = 32'h0; p_b0 = 32'h0; p_a1 = 32'h0; p_b1 = 32'h0;
    q_reset = 1'b1; q_req0 = 1'b0; q_req1 = 1'b0;
    q_a0 = 32'h0; q_b0 = 32'h0; q_a1 = 32'h0; q_b1 = 32'h0;
    tick();
    tick();

    // ---- reset state ----
    p_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.ops_done", 32'(p_ops), 32'd0);
    chk("rst.mul_a", p_mul_a, 32'h0);
    chk("rst.mul_start", 32'(p_start), 32'd0);
    chk("rst.rsp_result", p_res, 32'h0);
    p_reset = 1'b0;
    q_reset = 1'b0;

    // ---- 1: single op on port 0, 2.0*3.0 ----
    p_req0 = 1'b1; p_a0 = 32'h4000_0000; p_b0 = 32'h4040_0000;
    tick();
    p_outs("t1.grant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1.mul_start", 32'(p_start), 32'd1);
    chk("t1.mul_a", p_mul_a, 32'h4000_0000);
    chk("t1.mul_b", p_mul_b, 32'h4040_0000);
    p_req0 = 1'b0;
    tick();
    p_outs("t1.rsp", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t1.result", p_res, 32'h40C0_0000);
    chk("t1.especial", 32'(p_esp), 32'd0);
    chk("t1.ops_done", 32'(p_ops), 32'd1);
    chk("t1.mul_start_low", 32'(p_start), 32'd0);
    tick();
    p_outs("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1.result_held", p_res, 32'h40C0_0000);

    // ---- 2: both held after reset -> 0,1,0,1 ----
    p_reset = 1'b1;
    tick();
    p_reset = 1'b0;
    p_req0 = 1'b1; p_a0 = 32'h3FC0_0000; p_b0 = 32'h4000_0000;
    p_req1 = 1'b1; p_a1 = 32'h4080_0000; p_b1 = 32'h3F00_0000;
    for (int i = 0; i < 4; i++) begin
      exp_res = (i % 2 == 0) ? 32'h4040_0000 : 32'h4000_0000;
      tick();
      p_outs($sformatf("t2.grant%0d", i), (i % 2 == 0), (i % 2 == 1), 1'b0, 1'b0, 1'b1);
      tick();
      p_outs($sformatf("t2.rsp%0d", i), 1'b0, 1'b0, (i % 2 == 0), (i % 2 == 1), 1'b1);
      chk($sformatf("t2.result%0d", i), p_res, exp_res);
      chk($sformatf("t2.ops%0d", i), 32'(p_ops), 32'(i + 1));
      tick();
      chk($sformatf("t2.idle%0d", i), 32'(p_busy), 32'd0);
    end
    p_req0 = 1'b0;
    p_req1 = 1'b0;
    tick();

    // ---- 4: zero operand on port 1 -> especial 01 ----
    p_req1 = 1'b1; p_a1 = 32'h0000_0000; p_b1 = 32'h3F80_0000;
    tick();
    p_outs("t4.grant", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    p_req1 = 1'b0;
    tick();
    p_outs("t4.rsp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t4.especial", 32'(p_esp), 32'd1);
    chk("t4.result", p_res, 32'h0000_0000);
    chk("t4.ops_done", 32'(p_ops), 32'd5);
    tick();

    // ---- 5: reset during BUSY, held req1 granted after release ----
    p_req1 = 1'b1; p_a1 = 32'h4000_0000; p_b1 = 32'h4040_0000;
    tick();
    p_outs("t5.grant", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    p_reset = 1'b1;
    #1;
    p_outs("t5.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5.async.ops", 32'(p_ops), 32'd0);
    chk("t5.async.mul_a", p_mul_a, 32'h0);
    chk("t5.async.start", 32'(p_start), 32'd0);
    tick();
    p_outs("t5.held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    p_reset = 1'b0;
    tick();
    p_outs("t5.regrant", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5.regrant.mul_a", p_mul_a, 32'h4000_0000);
    p_req1 = 1'b0;
    tick();
    p_outs("t5.rsp", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5.result", p_res, 32'h40C0_0000);
    chk("t5.ops_done", 32'(p_ops), 32'd1);

    // ---- 3: MUL_LAT=3 instance ----
    q_req0 = 1'b1; q_a0 = 32'h4000_0000; q_b0 = 32'h4040_0000;
    tick();
    q_outs("t3.grant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    q_req0 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      q_outs($sformatf("t3.wait%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    tick();
    q_outs("t3.rsp", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t3.result", q_res, 32'h40C0_0000);
    chk("t3.especial", 32'(q_esp), 32'd0);
    chk("t3.ops_done", 32'(q_ops), 32'd1);
    tick();
    q_outs("t3.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- 6: 2-bit ops_done wraps after 4 ops ----
    for (int k = 2; k <= 4; k++) begin
      q_req0 = 1'b1;
      tick();
      chk($sformatf("t6.gnt0_%0d", k), 32'(q_gnt0), 32'd1);
      q_req0 = 1'b0;
      tick(); tick(); tick(); tick();
      chk($sformatf("t6.rsp_%0d", k), 32'(q_v0), 32'd1);
      chk($sformatf("t6.ops_%0d", k), 32'(q_ops), 32'(k % 4));
      tick();
    end
    chk("t6.wrapped", 32'(q_ops), 32'd0);

    // ---- 6b: req pulse dropped before any edge samples it ----
    @(posedge clk);
    #2;
    q_req1 = 1'b1;
    #3;
    q_req1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      q_outs($sformatf("t6.pulse%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
